// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller and its clients: the byte-wide
// RAM port, the UART back-pressure flag, the instruction-fetch port and the
// load/store port.
interface mem_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic        if_en;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_data;

  logic        lsb_en;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  // Controller side
  modport slave (
    input  mem_din, io_buffer_full,
    input  if_en, if_pc,
    input  lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data,
    output lsb_done, lsb_rdata
  );

  // Client / RAM side
  modport master (
    output mem_din, io_buffer_full,
    output if_en, if_pc,
    output lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data,
    input  lsb_done, lsb_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and
// load/store requests onto a single 8-bit RAM port, one transaction at a
// time. Reads assemble bytes little-endian; writes to the UART window
// (addr[17:16] == 2'b11) stall while the UART buffer is full.
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      rob_clear,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IF_RD = 2'd1;
  localparam logic [1:0] LS_RD = 2'd2;
  localparam logic [1:0] LS_WR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic [31:0] byte_addr_s;
  logic [31:0] next_addr_s;
  logic [31:0] buf_cap_s;
  logic [7:0]  wbyte_s;
  logic        io_stall_s;
  logic        accept_s;
  logic        lsb_take_s;

  // cnt counts bytes issued (writes) or cycles spent in the read state
  assign byte_addr_s = addr_q + {29'd0, cnt_q};
  assign next_addr_s = addr_q + {29'd0, cnt_q} + 32'd1;
  assign io_stall_s  = (byte_addr_s[17:16] == 2'b11) && bus.io_buffer_full;
  // The done cycle is spent in IDLE; a still-held enable must not restart
  assign accept_s    = (state_q == IDLE) && !if_done_q && !lsb_done_q;
  // A flush kills a speculative load in the cycle it would be accepted
  assign lsb_take_s  = bus.lsb_en && !(rob_clear && !bus.lsb_wr);

  // Select the store byte addressed by the byte counter
  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wbyte_s = wdata_q[7:0];
      2'd1:    wbyte_s = wdata_q[15:8];
      2'd2:    wbyte_s = wdata_q[23:16];
      2'd3:    wbyte_s = wdata_q[31:24];
      default: wbyte_s = 8'd0;
    endcase
  end

  // Merge the returning RAM byte into the read buffer (byte cnt-1)
  always_comb begin
    buf_cap_s = buf_q;
    case (cnt_q)
      3'd1:    buf_cap_s[7:0]   = bus.mem_din;
      3'd2:    buf_cap_s[15:8]  = bus.mem_din;
      3'd3:    buf_cap_s[23:16] = bus.mem_din;
      3'd4:    buf_cap_s[31:24] = bus.mem_din;
      default: buf_cap_s = buf_q;
    endcase
  end

  // Transaction FSM: next state, RAM port drive and completion pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        mem_a_d  = 32'd0;
        cnt_d    = 3'd0;
        buf_d    = 32'd0;
        if (accept_s && lsb_take_s) begin
          addr_d  = bus.lsb_addr;
          len_d   = {1'b0, bus.lsb_len} + 3'd1;
          wdata_d = bus.lsb_wdata;
          if (bus.lsb_wr) begin
            state_d = LS_WR;
            if ((bus.lsb_addr[17:16] == 2'b11) && bus.io_buffer_full) begin
              mem_wr_d = 1'b0;
            end else begin
              mem_a_d    = bus.lsb_addr;
              mem_dout_d = bus.lsb_wdata[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = LS_RD;
            mem_a_d = bus.lsb_addr;
          end
        end else if (accept_s && bus.if_en) begin
          state_d = IF_RD;
          addr_d  = bus.if_pc;
          len_d   = 3'd4;
          mem_a_d = bus.if_pc;
        end else begin
          state_d = IDLE;
        end
      end
      IF_RD, LS_RD: begin
        if ((state_q == LS_RD) && rob_clear) begin
          state_d = IDLE;
          mem_a_d = 32'd0;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          buf_d = buf_cap_s;
          if ((cnt_q + 3'd1) < len_q) begin
            mem_a_d = next_addr_s;
          end else begin
            mem_a_d = 32'd0;
          end
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_data_d = buf_cap_s;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_cap_s;
            end
          end else begin
            state_d = state_q;
          end
        end
      end
      LS_WR: begin
        if (cnt_q == len_q) begin
          state_d    = IDLE;
          mem_wr_d   = 1'b0;
          mem_a_d    = 32'd0;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
        end else if (io_stall_s) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_a_d    = byte_addr_s;
          mem_dout_d = wbyte_s;
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
        mem_a_d  = 32'd0;
        cnt_d    = 3'd0;
      end
    endcase
  end

  // State register: reset dominates, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= 32'd0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected read words and written bytes are
// queued when a request is driven and popped when the DUT reports them.
// Offset 0 of every scenario is the cycle in which the request is accepted.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, rob_clear;
  mem_ctrl_if bus();

  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] lsb_exp_q[$];
  logic [39:0] wr_exp_q[$];

  localparam int W = 32;
  logic [31:0] o_a[W];
  logic [7:0]  o_dout[W];
  logic        o_wr[W], o_ifd[W], o_lsd[W], o_io[W];
  logic [31:0] o_ifdata[W], o_lsdata[W];
  logic        s_rdy[W], s_clr[W], s_io[W], s_scr[W], s_ldrop[W];

  // Byte RAM model, one-cycle read latency; frozen with the rest of the system
  logic [7:0] ram [0:262143];
  initial begin
    ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h05;
    ram[18'h00102] = 8'h00; ram[18'h00103] = 8'h00;
    ram[18'h00104] = 8'h78; ram[18'h00105] = 8'h56;
    ram[18'h00106] = 8'h34; ram[18'h00107] = 8'h12;
    ram[18'h00200] = 8'hFF;
    ram[18'h00400] = 8'h11; ram[18'h00401] = 8'h22;
    ram[18'h00402] = 8'h33; ram[18'h00403] = 8'h44;
    ram[18'h3FFFF] = 8'hA5; ram[18'h00000] = 8'h3C;
    forever begin
      @(posedge clk);
      if (rdy) begin
        if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[17:0]];
      end
    end
  end

  task automatic clear_sched();
    for (int i = 0; i < W; i++) begin
      s_rdy[i] = 1'b1; s_clr[i] = 1'b0; s_io[i] = 1'b0; s_scr[i] = 1'b0; s_ldrop[i] = 1'b0;
    end
  endtask

  // Apply per-cycle schedule, sample at negedge, drop an enable once its done is seen
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      rdy = s_rdy[i]; rob_clear = s_clr[i]; bus.io_buffer_full = s_io[i];
      if (s_ldrop[i]) bus.lsb_en = 1'b0;
      if (s_scr[i]) begin
        bus.lsb_addr = 32'hABCD_0000; bus.lsb_wdata = 32'h0; bus.lsb_len = 2'd0;
      end
      @(negedge clk);
      o_a[i] = bus.mem_a; o_dout[i] = bus.mem_dout; o_wr[i] = bus.mem_wr;
      o_ifd[i] = bus.if_done; o_lsd[i] = bus.lsb_done; o_io[i] = bus.io_buffer_full;
      o_ifdata[i] = bus.if_data; o_lsdata[i] = bus.lsb_rdata;
      if (bus.if_done) bus.if_en = 1'b0;
      if (bus.lsb_done) bus.lsb_en = 1'b0;
      @(posedge clk); #1;
    end
    rdy = 1'b1; rob_clear = 1'b0; bus.io_buffer_full = 1'b0;
  endtask

  task automatic settle();
    bus.if_en = 1'b0; bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0;
    rdy = 1'b1; rob_clear = 1'b0; bus.io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_sched();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int cnt;
    // rst held with rdy low: reset must still win
    @(negedge clk);
    v = bus.mem_a;     n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mem_a got=%h exp=0", v); end
    v = {24'd0, bus.mem_dout}; n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mem_dout got=%h exp=0", v); end
    n_tests++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got=%b exp=0", bus.mem_wr); end
    n_tests++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done got=%b exp=0", bus.if_done); end
    n_tests++; if (bus.lsb_done !== 1'b0) begin n_fail++; $display("FAIL reset_lsb_done got=%b exp=0", bus.lsb_done); end
    v = bus.if_data;   n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_if_data got=%h exp=0", v); end
    v = bus.lsb_rdata; n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_lsb_rdata got=%h exp=0", v); end
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b1;
    // reset in the middle of a fetch abandons it silently
    bus.if_en = 1'b1; bus.if_pc = 32'h100;
    run(3);
    rst = 1'b1; bus.if_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run(10);
    cnt = 0;
    for (int i = 0; i < 10; i++) if (o_ifd[i]) cnt++;
    n_tests++; if (cnt != 0) begin n_fail++; $display("FAIL reset_abort_done got=%0d exp=0", cnt); end
    n_tests++; if (o_a[0] !== 32'd0) begin n_fail++; $display("FAIL reset_abort_mem_a got=%h exp=0", o_a[0]); end
    settle();
  endtask

  task automatic test_fetch();
    int d, cnt, wr;
    logic [31:0] e;
    if_exp_q.push_back(32'h0000_0513);
    bus.if_en = 1'b1; bus.if_pc = 32'h100;
    run(10);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (o_a[k+1] !== 32'h100 + k) begin n_fail++; $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", k+1, o_a[k+1], 32'h100 + k); end
    end
    d = -1; cnt = 0; wr = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_wr[i]) wr++;
      if (o_ifd[i]) begin
        cnt++;
        if (d < 0) d = i;
        if (if_exp_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL fetch_extra_done cyc=%0d got=1 exp=0", i);
        end else begin
          e = if_exp_q.pop_front();
          n_tests++; if (o_ifdata[i] !== e) begin n_fail++; $display("FAIL fetch_data got=%h exp=%h", o_ifdata[i], e); end
        end
      end
    end
    n_tests++; if (d != 6) begin n_fail++; $display("FAIL fetch_done_cycle got=%0d exp=6", d); end
    n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL fetch_done_count got=%0d exp=1", cnt); end
    n_tests++; if (wr != 0) begin n_fail++; $display("FAIL fetch_mem_wr got=%0d exp=0", wr); end
    n_tests++; if (o_a[7] !== 32'd0) begin n_fail++; $display("FAIL fetch_idle_mem_a got=%h exp=0", o_a[7]); end
    n_tests++; if (o_ifdata[9] !== 32'h0000_0513) begin n_fail++; $display("FAIL fetch_data_hold got=%h exp=00000513", o_ifdata[9]); end
    settle();
  endtask

  task automatic test_priority();
    int di, dl, ci, cl;
    logic [31:0] e;
    lsb_exp_q.push_back(32'h0000_00FF);
    if_exp_q.push_back(32'h1234_5678);
    bus.if_en = 1'b1; bus.if_pc = 32'h104;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd0; bus.lsb_addr = 32'h200;
    run(14);
    di = -1; dl = -1; ci = 0; cl = 0;
    for (int i = 0; i < 14; i++) begin
      if (o_lsd[i]) begin
        cl++; if (dl < 0) dl = i;
        if (lsb_exp_q.size() != 0) begin
          e = lsb_exp_q.pop_front();
          n_tests++; if (o_lsdata[i] !== e) begin n_fail++; $display("FAIL prio_lsb_data got=%h exp=%h", o_lsdata[i], e); end
        end
      end
      if (o_ifd[i]) begin
        ci++; if (di < 0) di = i;
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          n_tests++; if (o_ifdata[i] !== e) begin n_fail++; $display("FAIL prio_if_data got=%h exp=%h", o_ifdata[i], e); end
        end
      end
    end
    n_tests++; if (dl != 3) begin n_fail++; $display("FAIL prio_lsb_cycle got=%0d exp=3", dl); end
    n_tests++; if (di != 10) begin n_fail++; $display("FAIL prio_if_cycle got=%0d exp=10", di); end
    n_tests++; if (ci != 1 || cl != 1) begin n_fail++; $display("FAIL prio_done_counts got=%0d/%0d exp=1/1", ci, cl); end
    settle();
  endtask

  task automatic test_store();
    int d, cnt;
    logic [39:0] e;
    logic [31:0] mem_word;
    for (int k = 0; k < 4; k++) begin
      e = {32'h300 + k, 8'(32'hDEAD_BEEF >> (8 * k))};
      wr_exp_q.push_back(e);
    end
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 2'd3;
    bus.lsb_addr = 32'h300; bus.lsb_wdata = 32'hDEAD_BEEF;
    s_scr[1] = 1'b1;
    run(9);
    d = -1; cnt = 0;
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (o_wr[i] !== ((i >= 1) && (i <= 4))) begin n_fail++; $display("FAIL store_mem_wr cyc=%0d got=%b exp=%b", i, o_wr[i], (i >= 1) && (i <= 4)); end
      if (o_wr[i] && wr_exp_q.size() != 0) begin
        e = wr_exp_q.pop_front();
        n_tests++; if ({o_a[i], o_dout[i]} !== e) begin n_fail++; $display("FAIL store_byte cyc=%0d got=%h exp=%h", i, {o_a[i], o_dout[i]}, e); end
      end
      if (o_lsd[i]) begin cnt++; if (d < 0) d = i; end
    end
    n_tests++; if (d != 5 || cnt != 1) begin n_fail++; $display("FAIL store_done got=cyc%0d/n%0d exp=cyc5/n1", d, cnt); end
    mem_word = {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]};
    n_tests++; if (mem_word !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_ram got=%h exp=deadbeef", mem_word); end
    settle();
  endtask

  task automatic test_stall();
    int d, cnt, wr, wcyc;
    logic [39:0] e;
    wr_exp_q.push_back({32'h0003_0000, 8'h5A});
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 2'd0;
    bus.lsb_addr = 32'h0003_0000; bus.lsb_wdata = 32'h0000_005A;
    s_io[0] = 1'b1; s_io[1] = 1'b1; s_io[2] = 1'b1;
    run(10);
    d = -1; cnt = 0; wr = 0; wcyc = -1;
    for (int i = 0; i < 10; i++) begin
      if (o_io[i]) begin
        n_tests++; if (o_wr[i] !== 1'b0) begin n_fail++; $display("FAIL stall_mem_wr cyc=%0d got=1 exp=0", i); end
      end
      if (o_wr[i]) begin
        wr++; wcyc = i;
        if (wr_exp_q.size() != 0) begin
          e = wr_exp_q.pop_front();
          n_tests++; if ({o_a[i], o_dout[i]} !== e) begin n_fail++; $display("FAIL stall_byte got=%h exp=%h", {o_a[i], o_dout[i]}, e); end
        end
      end
      if (o_lsd[i]) begin cnt++; if (d < 0) d = i; end
    end
    n_tests++; if (wr != 1) begin n_fail++; $display("FAIL stall_write_count got=%0d exp=1", wr); end
    n_tests++; if (cnt != 1 || d != wcyc + 1) begin n_fail++; $display("FAIL stall_done got=cyc%0d/n%0d exp=cyc%0d/n1", d, cnt, wcyc + 1); end
    n_tests++; if (ram[18'h30000] !== 8'h5A) begin n_fail++; $display("FAIL stall_ram got=%h exp=5a", ram[18'h30000]); end
    settle();
  endtask

  task automatic test_abort();
    int d, ci, cl;
    logic [31:0] e;
    if_exp_q.push_back(32'h0000_0513);
    bus.if_en = 1'b1; bus.if_pc = 32'h100;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd3; bus.lsb_addr = 32'h400;
    s_clr[2] = 1'b1; s_ldrop[2] = 1'b1;
    run(14);
    d = -1; ci = 0; cl = 0;
    for (int i = 0; i < 14; i++) begin
      if (o_lsd[i]) cl++;
      if (o_ifd[i]) begin
        ci++; if (d < 0) d = i;
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          n_tests++; if (o_ifdata[i] !== e) begin n_fail++; $display("FAIL abort_if_data got=%h exp=%h", o_ifdata[i], e); end
        end
      end
    end
    n_tests++; if (cl != 0) begin n_fail++; $display("FAIL abort_lsb_done got=%0d exp=0", cl); end
    n_tests++; if (o_a[3] !== 32'd0) begin n_fail++; $display("FAIL abort_idle_mem_a got=%h exp=0", o_a[3]); end
    n_tests++; if (d != 9 || ci != 1) begin n_fail++; $display("FAIL abort_if_done got=cyc%0d/n%0d exp=cyc9/n1", d, ci); end
    settle();
  endtask

  task automatic test_clear_idle();
    int d, ci, cl;
    logic [31:0] e;
    if_exp_q.push_back(32'h1234_5678);
    bus.if_en = 1'b1; bus.if_pc = 32'h104;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd0; bus.lsb_addr = 32'h200;
    s_clr[0] = 1'b1; s_ldrop[1] = 1'b1;
    run(10);
    d = -1; ci = 0; cl = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_lsd[i]) cl++;
      if (o_ifd[i]) begin
        ci++; if (d < 0) d = i;
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          n_tests++; if (o_ifdata[i] !== e) begin n_fail++; $display("FAIL clear_if_data got=%h exp=%h", o_ifdata[i], e); end
        end
      end
    end
    n_tests++; if (cl != 0) begin n_fail++; $display("FAIL clear_lsb_done got=%0d exp=0", cl); end
    n_tests++; if (d != 6 || ci != 1) begin n_fail++; $display("FAIL clear_if_done got=cyc%0d/n%0d exp=cyc6/n1", d, ci); end
    settle();
  endtask

  task automatic test_wrap();
    int d;
    logic [31:0] e;
    lsb_exp_q.push_back(32'h0000_3CA5);
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd1; bus.lsb_addr = 32'hFFFF_FFFF;
    run(8);
    n_tests++; if (o_a[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr0 got=%h exp=ffffffff", o_a[1]); end
    n_tests++; if (o_a[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got=%h exp=0", o_a[2]); end
    d = -1;
    for (int i = 0; i < 8; i++) begin
      if (o_lsd[i]) begin
        if (d < 0) d = i;
        if (lsb_exp_q.size() != 0) begin
          e = lsb_exp_q.pop_front();
          n_tests++; if (o_lsdata[i] !== e) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", o_lsdata[i], e); end
        end
      end
    end
    n_tests++; if (d != 4) begin n_fail++; $display("FAIL wrap_done_cycle got=%0d exp=4", d); end
    settle();
  endtask

  task automatic test_rdy();
    int d, ci;
    logic [31:0] e;
    if_exp_q.push_back(32'h1234_5678);
    bus.if_en = 1'b1; bus.if_pc = 32'h104;
    s_rdy[3] = 1'b0; s_rdy[4] = 1'b0; s_rdy[5] = 1'b0;
    run(14);
    for (int i = 3; i <= 6; i++) begin
      n_tests++; if (o_a[i] !== 32'h106) begin n_fail++; $display("FAIL rdy_hold_mem_a cyc=%0d got=%h exp=106", i, o_a[i]); end
    end
    d = -1; ci = 0;
    for (int i = 0; i < 14; i++) begin
      if (o_ifd[i]) begin
        ci++; if (d < 0) d = i;
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          n_tests++; if (o_ifdata[i] !== e) begin n_fail++; $display("FAIL rdy_if_data got=%h exp=%h", o_ifdata[i], e); end
        end
      end
    end
    n_tests++; if (d != 9 || ci != 1) begin n_fail++; $display("FAIL rdy_if_done got=cyc%0d/n%0d exp=cyc9/n1", d, ci); end
    settle();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; rob_clear = 1'b0;
    bus.if_en = 1'b0; bus.if_pc = 32'd0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'd0;
    bus.lsb_len = 2'd0; bus.lsb_wdata = 32'd0; bus.io_buffer_full = 1'b0;
    clear_sched();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_stall();
    test_abort();
    test_clear_idle();
    test_wrap();
    test_rdy();
    n_tests++;
    if (if_exp_q.size() + lsb_exp_q.size() + wr_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", if_exp_q.size() + lsb_exp_q.size() + wr_exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
